// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control unit for a multicycle RF+ALU datapath. Holds the
// FETCH/ID/EXE/MEM/WB/HALT state machine and decodes the latched instruction
// word into every datapath, PC, IR, PSW and memory strobe. It also counts
// retired instructions.
//
// Ports:
//   clk         in   sole clock, rising edge
//   Reset       in   synchronous, active-low reset
//   Ins[15:0]   in   IR contents, opcode in Ins[15:11]
//   MemReady    in   memory handshake, sampled only in MEM
//   WBRF        out  RF write enable
//   WBresource  out  RF write source (1: Sum/LI_EXE, 0: WBData)
//   RBresource  out  RF read port B address (1: Ins[10:8], 0: Ins[4:2])
//   OprandB     out  ALU B operand (1: imm5, 0: RF)
//   LI          out  load-immediate form (1: LHI, 0: LLI)
//   Buff_IDEXE  out  load the ID/EXE buffer
//   PSW_C, ALUop, Flag  out  ALU control
//   PSWwe       out  load C/Z/N into PSW
//   IRload      out  load IR from instruction memory
//   PCwrite     out  PC update enable
//   PCsel[1:0]  out  PC source (00 PC+1, 01 label, 10 JALR reg, 11 JR reg)
//   MemRead, MemWrite  out  data-memory strobes
//   Halt        out  processor halted
//   State[2:0]  out  current state (FETCH=0 .. WB=4, HALT=7)
//   RetCnt      out  retired-instruction count, wraps modulo 2^CNT_W
//
// All strobes are a combinational decode of (state, opcode) and are forced
// to zero while Reset is low.
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [15:0]      Ins,
    input  logic             MemReady,
    output logic             WBRF,
    output logic             WBresource,
    output logic             RBresource,
    output logic             OprandB,
    output logic             LI,
    output logic             Buff_IDEXE,
    output logic             PSW_C,
    output logic             ALUop,
    output logic             Flag,
    output logic             PSWwe,
    output logic             IRload,
    output logic             PCwrite,
    output logic [1:0]       PCsel,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Halt,
    output logic [2:0]       State,
    output logic [CNT_W-1:0] RetCnt
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_ID    = 3'd1,
        S_EXE   = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd7
    } state_t;

    localparam logic [4:0] OP_NOP    = 5'b00000;
    localparam logic [4:0] OP_LHI    = 5'b00001;
    localparam logic [4:0] OP_LLI    = 5'b00010;
    localparam logic [4:0] OP_LDR_RI = 5'b00011;
    localparam logic [4:0] OP_LDR_RR = 5'b00100;
    localparam logic [4:0] OP_STR_RI = 5'b00101;
    localparam logic [4:0] OP_STR_RR = 5'b00110;
    localparam logic [4:0] OP_ADD    = 5'b00111;
    localparam logic [4:0] OP_ADC    = 5'b01000;
    localparam logic [4:0] OP_SUB    = 5'b01001;
    localparam logic [4:0] OP_SBB    = 5'b01010;
    localparam logic [4:0] OP_CMP    = 5'b01011;
    localparam logic [4:0] OP_ADDI   = 5'b01100;
    localparam logic [4:0] OP_SUBI   = 5'b01101;
    localparam logic [4:0] OP_MOV    = 5'b01110;
    localparam logic [4:0] OP_JAL    = 5'b01111;
    localparam logic [4:0] OP_JALR   = 5'b10000;
    localparam logic [4:0] OP_JR     = 5'b10001;
    localparam logic [4:0] OP_OUTR   = 5'b10010;
    localparam logic [4:0] OP_HLT    = 5'b11111;

    // Opcode class helpers.
    function automatic logic is_ldr(input logic [4:0] op);
        return (op == OP_LDR_RI) || (op == OP_LDR_RR);
    endfunction

    function automatic logic is_str(input logic [4:0] op);
        return (op == OP_STR_RI) || (op == OP_STR_RR);
    endfunction

    // Ops that update C/Z/N.
    function automatic logic is_psw_op(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_ADC) || (op == OP_SUB) ||
               (op == OP_SBB) || (op == OP_CMP) || (op == OP_ADDI) ||
               (op == OP_SUBI);
    endfunction

    // Everything that carries operands into EXE/WB loads the ID/EXE buffer;
    // jumps, halt, NOP and undefined opcodes do not.
    function automatic logic needs_buff(input logic [4:0] op);
        return ((op >= OP_LHI) && (op <= OP_MOV)) || (op == OP_OUTR);
    endfunction

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic             retire_s;
    logic [4:0]       op_s;

    logic             wbrf_s;
    logic             wbres_s;
    logic             rbres_s;
    logic             oprandb_s;
    logic             li_s;
    logic             buff_s;
    logic             psw_c_s;
    logic             aluop_s;
    logic             flag_s;
    logic             pswwe_s;
    logic             irload_s;
    logic             pcwrite_s;
    logic [1:0]       pcsel_s;
    logic             memread_s;
    logic             memwrite_s;
    logic             halt_s;

    // Register fields are consumed by the datapath, not by this controller.
    logic             unused_ins_s;

    assign op_s         = Ins[15:11];
    assign unused_ins_s = ^Ins[10:0];

    // Next-state and raw strobe decode from the current state and opcode.
    always_comb begin
        next_state_s = S_FETCH;
        retire_s     = 1'b0;
        wbrf_s       = 1'b0;
        wbres_s      = 1'b0;
        rbres_s      = 1'b0;
        oprandb_s    = 1'b0;
        li_s         = 1'b0;
        buff_s       = 1'b0;
        psw_c_s      = 1'b0;
        aluop_s      = 1'b0;
        flag_s       = 1'b0;
        pswwe_s      = 1'b0;
        irload_s     = 1'b0;
        pcwrite_s    = 1'b0;
        pcsel_s      = 2'b00;
        memread_s    = 1'b0;
        memwrite_s   = 1'b0;
        halt_s       = 1'b0;

        case (state_r)
            S_FETCH: begin
                irload_s     = 1'b1;
                pcwrite_s    = 1'b1;
                pcsel_s      = 2'b00;
                next_state_s = S_ID;
            end

            S_ID: begin
                buff_s = needs_buff(op_s);
                case (op_s)
                    OP_LHI: begin
                        rbres_s      = 1'b1;
                        li_s         = 1'b1;
                        next_state_s = S_WB;
                    end
                    OP_LLI: begin
                        li_s         = 1'b0;
                        next_state_s = S_WB;
                    end
                    OP_LDR_RI, OP_STR_RI, OP_ADDI, OP_SUBI: begin
                        oprandb_s    = 1'b1;
                        next_state_s = S_EXE;
                    end
                    OP_LDR_RR, OP_STR_RR, OP_ADD, OP_ADC,
                    OP_SUB, OP_SBB, OP_CMP: begin
                        rbres_s      = 1'b0;
                        oprandb_s    = 1'b0;
                        next_state_s = S_EXE;
                    end
                    OP_MOV: begin
                        next_state_s = S_WB;
                    end
                    OP_JAL: begin
                        wbrf_s       = 1'b1;
                        wbres_s      = 1'b1;
                        pcwrite_s    = 1'b1;
                        pcsel_s      = 2'b01;
                        next_state_s = S_FETCH;
                    end
                    OP_JALR: begin
                        wbrf_s       = 1'b1;
                        wbres_s      = 1'b1;
                        pcwrite_s    = 1'b1;
                        pcsel_s      = 2'b10;
                        next_state_s = S_FETCH;
                    end
                    OP_JR: begin
                        wbrf_s       = 1'b1;
                        wbres_s      = 1'b1;
                        rbres_s      = 1'b1;
                        pcwrite_s    = 1'b1;
                        pcsel_s      = 2'b11;
                        next_state_s = S_FETCH;
                    end
                    OP_HLT: begin
                        next_state_s = S_HALT;
                    end
                    default: begin
                        // NOP, OUTR and undefined opcodes finish here.
                        next_state_s = S_FETCH;
                    end
                endcase
                retire_s = (next_state_s == S_FETCH) || (next_state_s == S_HALT);
            end

            S_EXE: begin
                case (op_s)
                    OP_LDR_RI, OP_LDR_RR, OP_STR_RI, OP_STR_RR,
                    OP_ADD, OP_ADDI: {psw_c_s, aluop_s, flag_s} = 3'b100;
                    OP_ADC:          {psw_c_s, aluop_s, flag_s} = 3'b101;
                    OP_SUB, OP_SUBI,
                    OP_CMP:          {psw_c_s, aluop_s, flag_s} = 3'b010;
                    OP_SBB:          {psw_c_s, aluop_s, flag_s} = 3'b011;
                    default:         {psw_c_s, aluop_s, flag_s} = 3'b000;
                endcase
                pswwe_s = is_psw_op(op_s);
                // Stores read the data register through port B during EXE.
                rbres_s = is_str(op_s);
                if (is_ldr(op_s) || is_str(op_s)) begin
                    next_state_s = S_MEM;
                end else if (op_s == OP_CMP) begin
                    next_state_s = S_FETCH;
                    retire_s     = 1'b1;
                end else begin
                    next_state_s = S_WB;
                end
            end

            S_MEM: begin
                memread_s  = is_ldr(op_s);
                memwrite_s = is_str(op_s);
                if (!(is_ldr(op_s) || is_str(op_s))) begin
                    // Unreachable for a stable Ins; recover to FETCH.
                    next_state_s = S_FETCH;
                    retire_s     = 1'b1;
                end else if (!MemReady) begin
                    next_state_s = S_MEM;
                end else if (is_ldr(op_s)) begin
                    next_state_s = S_WB;
                end else begin
                    next_state_s = S_FETCH;
                    retire_s     = 1'b1;
                end
            end

            S_WB: begin
                wbrf_s       = 1'b1;
                wbres_s      = !is_ldr(op_s);
                next_state_s = S_FETCH;
                retire_s     = 1'b1;
            end

            S_HALT: begin
                halt_s       = 1'b1;
                next_state_s = S_HALT;
            end

            default: begin
                next_state_s = S_FETCH;
            end
        endcase
    end

    // State register and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_r <= S_FETCH;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (retire_s) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Output gating: every output reads zero while reset is held.
    always_comb begin
        if (Reset) begin
            WBRF       = wbrf_s;
            WBresource = wbres_s;
            RBresource = rbres_s;
            OprandB    = oprandb_s;
            LI         = li_s;
            Buff_IDEXE = buff_s;
            PSW_C      = psw_c_s;
            ALUop      = aluop_s;
            Flag       = flag_s;
            PSWwe      = pswwe_s;
            IRload     = irload_s;
            PCwrite    = pcwrite_s;
            PCsel      = pcsel_s;
            MemRead    = memread_s;
            MemWrite   = memwrite_s;
            Halt       = halt_s;
            State      = state_r;
            RetCnt     = cnt_r;
        end else begin
            WBRF       = 1'b0;
            WBresource = 1'b0;
            RBresource = 1'b0;
            OprandB    = 1'b0;
            LI         = 1'b0;
            Buff_IDEXE = 1'b0;
            PSW_C      = 1'b0;
            ALUop      = 1'b0;
            Flag       = 1'b0;
            PSWwe      = 1'b0;
            IRload     = 1'b0;
            PCwrite    = 1'b0;
            PCsel      = 2'b00;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            Halt       = 1'b0;
            State      = 3'b000;
            RetCnt     = {CNT_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Scoreboard bench for multicycle_ctrl. Each cycle the expected output vector
// and retired count, derived from a per-state behavioural model of the
// controller, are pushed when the inputs are driven and popped/compared at
// the following falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_ID    = 3'd1;
    localparam logic [2:0] S_EXE   = 3'd2;
    localparam logic [2:0] S_MEM   = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;
    localparam logic [2:0] S_HALT  = 3'd7;

    logic        clk;
    logic        Reset;
    logic [15:0] Ins;
    logic        MemReady;
    logic        WBRF, WBresource, RBresource, OprandB, LI, Buff_IDEXE;
    logic        PSW_C, ALUop, Flag, PSWwe, IRload, PCwrite;
    logic [1:0]  PCsel;
    logic        MemRead, MemWrite, Halt;
    logic [2:0]  State;
    logic [15:0] RetCnt;

    logic [19:0] obs_v;

    int          n_total;
    int          n_bad;
    logic [2:0]  m_st;
    logic [15:0] exp_ret;
    logic [19:0] exp_q[$];
    logic [15:0] ret_q[$];

    multicycle_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .Reset(Reset), .Ins(Ins), .MemReady(MemReady),
        .WBRF(WBRF), .WBresource(WBresource), .RBresource(RBresource),
        .OprandB(OprandB), .LI(LI), .Buff_IDEXE(Buff_IDEXE),
        .PSW_C(PSW_C), .ALUop(ALUop), .Flag(Flag), .PSWwe(PSWwe),
        .IRload(IRload), .PCwrite(PCwrite), .PCsel(PCsel),
        .MemRead(MemRead), .MemWrite(MemWrite), .Halt(Halt),
        .State(State), .RetCnt(RetCnt)
    );

    assign obs_v = {WBRF, WBresource, RBresource, OprandB, LI, Buff_IDEXE,
                    PSW_C, ALUop, Flag, PSWwe, IRload, PCwrite, PCsel,
                    MemRead, MemWrite, Halt, State};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Expected output vector for a state/opcode pair, written state by state.
    function automatic logic [19:0] model_out(input logic [2:0] st, input logic [4:0] op);
        logic wbrf = 1'b0, wbres = 1'b0, rb = 1'b0, ob = 1'b0, li = 1'b0, buff = 1'b0;
        logic [2:0] alu = 3'b000;
        logic pswwe = 1'b0, ir = 1'b0, pcw = 1'b0, mr = 1'b0, mw = 1'b0, hlt = 1'b0;
        logic [1:0] pcs = 2'b00;
        logic ldr, str;
        ldr = (op == 5'd3) || (op == 5'd4);
        str = (op == 5'd5) || (op == 5'd6);
        case (st)
            S_FETCH: begin ir = 1'b1; pcw = 1'b1; end
            S_ID: begin
                buff = (op >= 5'd1 && op <= 5'd14) || (op == 5'd18);
                if (op == 5'd1) begin rb = 1'b1; li = 1'b1; end
                if (op == 5'd3 || op == 5'd5 || op == 5'd12 || op == 5'd13) ob = 1'b1;
                if (op == 5'd15) begin wbrf = 1'b1; wbres = 1'b1; pcw = 1'b1; pcs = 2'b01; end
                if (op == 5'd16) begin wbrf = 1'b1; wbres = 1'b1; pcw = 1'b1; pcs = 2'b10; end
                if (op == 5'd17) begin wbrf = 1'b1; wbres = 1'b1; pcw = 1'b1; pcs = 2'b11; rb = 1'b1; end
            end
            S_EXE: begin
                if (ldr || str || op == 5'd7 || op == 5'd12) alu = 3'b100;
                if (op == 5'd8) alu = 3'b101;
                if (op == 5'd9 || op == 5'd13 || op == 5'd11) alu = 3'b010;
                if (op == 5'd10) alu = 3'b011;
                pswwe = (op >= 5'd7 && op <= 5'd13);
                rb = str;
            end
            S_MEM: begin mr = ldr; mw = str; end
            S_WB: begin wbrf = 1'b1; wbres = !ldr; end
            S_HALT: hlt = 1'b1;
            default: ;
        endcase
        return {wbrf, wbres, rb, ob, li, buff, alu, pswwe, ir, pcw, pcs, mr, mw, hlt, st};
    endfunction

    function automatic logic [2:0] model_next(input logic [2:0] st, input logic [4:0] op, input logic rdy);
        logic ldr, str;
        ldr = (op == 5'd3) || (op == 5'd4);
        str = (op == 5'd5) || (op == 5'd6);
        case (st)
            S_FETCH: return S_ID;
            S_ID: begin
                if (op == 5'd1 || op == 5'd2 || op == 5'd14) return S_WB;
                if (op >= 5'd3 && op <= 5'd13) return S_EXE;
                if (op == 5'd31) return S_HALT;
                return S_FETCH;
            end
            S_EXE: begin
                if (ldr || str) return S_MEM;
                if (op == 5'd11) return S_FETCH;
                return S_WB;
            end
            S_MEM: begin
                if (!rdy) return S_MEM;
                if (ldr) return S_WB;
                return S_FETCH;
            end
            S_HALT: return S_HALT;
            default: return S_FETCH;
        endcase
    endfunction

    // One scoreboarded cycle; entered #1 after a rising edge, leaves likewise.
    task automatic one_cycle(input string tag, input logic [15:0] ins, input logic rdy);
        logic [2:0] nx;
        Ins      = ins;
        MemReady = rdy;
        exp_q.push_back(model_out(m_st, ins[15:11]));
        ret_q.push_back(exp_ret);
        @(negedge clk);
        chk({tag, "/out"}, {12'd0, obs_v}, {12'd0, exp_q.pop_front()});
        chk({tag, "/ret"}, {16'd0, RetCnt}, {16'd0, ret_q.pop_front()});
        nx = model_next(m_st, ins[15:11], rdy);
        if (m_st != S_HALT && (nx == S_FETCH || nx == S_HALT)) exp_ret = exp_ret + 16'd1;
        m_st = nx;
        @(posedge clk);
        #1;
    endtask

    task automatic run_ins(input string tag, input logic [15:0] ins, input int waits, input int exp_cyc);
        int cyc;
        int wl;
        logic rdy;
        cyc = 0;
        wl  = waits;
        do begin
            if (m_st == S_MEM) begin
                rdy = (wl == 0);
                if (wl > 0) wl--;
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            one_cycle(tag, ins, rdy);
            cyc++;
        end while (m_st != S_FETCH && m_st != S_HALT && cyc < 50);
        chk({tag, "/cycles"}, cyc, exp_cyc);
    endtask

    initial begin
        n_total  = 0;
        n_bad    = 0;
        Reset    = 1'b0;
        Ins      = 16'h0000;
        MemReady = 1'b0;
        m_st     = S_FETCH;
        exp_ret  = 16'd0;

        // Reset held for three cycles: every output reads zero.
        repeat (3) begin
            @(negedge clk);
            chk("rst_out", {12'd0, obs_v}, 32'd0);
        end
        chk("rst_ret", {16'd0, RetCnt}, 32'd0);
        @(posedge clk);
        #1;
        Reset = 1'b1;

        run_ins("nop1", 16'h0000, 0, 2);
        chk("nop_ret", {16'd0, RetCnt}, 32'd1);
        run_ins("nop2", 16'h0000, 0, 2);
        run_ins("add",  16'h3828, 0, 4);
        run_ins("ldr",  16'h1800, 2, 7);
        run_ins("sbb",  16'h5000, 0, 4);
        run_ins("cmp",  16'h5800, 0, 3);
        run_ins("lhi",  16'h0800, 0, 3);
        run_ins("lli",  16'h1000, 0, 3);
        run_ins("mov",  16'h7000, 0, 3);
        run_ins("adc",  16'h4000, 0, 4);
        run_ins("subi", 16'h6800, 0, 4);
        run_ins("strr", 16'h3000, 1, 5);
        run_ins("ldrr", 16'h2000, 0, 5);
        run_ins("jal",  16'h7800, 0, 2);
        run_ins("jalr", 16'h8000, 0, 2);
        run_ins("outr", 16'h9000, 0, 2);
        run_ins("undef", 16'hA000, 0, 2);
        run_ins("jr",   16'h8800, 0, 2);
        run_ins("hlt",  16'hF800, 0, 2);

        // Halted for ten cycles, IR never reloaded.
        for (int i = 0; i < 10; i++) begin
            one_cycle("halt", 16'hF800, 1'b1);
            chk("halt_ir", {31'd0, IRload}, 32'd0);
        end

        // Reset leaves HALT.
        Reset = 1'b0;
        @(negedge clk);
        chk("hrst_out", {12'd0, obs_v}, 32'd0);
        @(posedge clk);
        #1;
        Reset   = 1'b1;
        m_st    = S_FETCH;
        exp_ret = 16'd0;
        run_ins("post_hlt", 16'h0000, 0, 2);

        // Reset during the MEM cycle of a store.
        for (int i = 0; i < 3; i++) one_cycle("str_pre", 16'h2800, 1'b0);
        Ins      = 16'h2800;
        MemReady = 1'b0;
        @(negedge clk);
        chk("str_mem_st", {29'd0, State}, {29'd0, S_MEM});
        chk("str_mem_we", {31'd0, MemWrite}, 32'd1);
        Reset = 1'b0;
        @(posedge clk);
        #1;
        Reset   = 1'b1;
        m_st    = S_FETCH;
        exp_ret = 16'd0;
        @(negedge clk);
        chk("str_rst_we",  {31'd0, MemWrite}, 32'd0);
        chk("str_rst_st",  {29'd0, State}, 32'd0);
        chk("str_rst_ret", {16'd0, RetCnt}, 32'd0);
        @(posedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
